mem_rw_test: RTL and testbench

//  Front-end sequencer driving the dual-port RAM controller from board buttons and switches.

---
 rtl/mem_rw_test.sv | 193 +++++++++++++++++++
 tb/tb_mem_rw_test.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rw_test.sv
// Button-driven front end for the dual-port RAM controller: manual read/write plus a full-memory self-test.
// Optional Done-timeout in wait states is enabled by defining MEMRW_TIMEOUT_EN.
module mem_rw_test #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              ar,
    input  logic [DATA_W-1:0] UniversalIn,
    input  logic              A_Button,
    input  logic              Rd_Button,
    input  logic              Wr_Button,
    input  logic              IT_Switch,
    input  logic [DATA_W-1:0] DOut,
    input  logic              Done,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] DIn,
    output logic              RD,
    output logic              WR,
    output logic              Done_LED,
    output logic              Internal_Pass_LED,
    output logic              Internal_Fail_LED,
    output logic [3:0]        SevenSeg_Three,
    output logic [3:0]        SevenSeg_Two,
    output logic [3:0]        SevenSeg_One,
    output logic [3:0]        SevenSeg_Zero
);

`ifdef MEMRW_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, M_WAIT, T_WR, T_WWAIT, T_RD, T_RWAIT, FIN
    } state_t;

    state_t            state;
    logic              is_read;
    logic [DATA_W-1:0] disp;
    logic [2:0]        sync [SYNC_STAGES];
    logic [2:0]        btn_prev;
    logic [2:0]        ev;
    logic              ev_a, ev_r, ev_w;
    logic              in_wait;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit;

    // Self-test data pattern: inverted low address bits above the address.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] addr);
        return DATA_W'({~addr[5:0], addr});
    endfunction

    // Button synchroniser chain and rising-edge detect; bit order {Wr, Rd, A}.
    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync[i] <= '0;
            btn_prev <= '0;
        end else begin
            sync[0] <= {Wr_Button, Rd_Button, A_Button};
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync[i] <= sync[i-1];
            btn_prev <= sync[SYNC_STAGES-1];
        end
    end

    assign ev   = sync[SYNC_STAGES-1] & ~btn_prev;
    assign ev_a = ev[0];
    assign ev_r = ev[1];
    assign ev_w = ev[2];

    assign in_wait = (state == M_WAIT) || (state == T_WWAIT) || (state == T_RWAIT);

    // Cycles spent in the current wait state without a Done pulse.
    always_ff @(posedge clk or posedge ar) begin
        if (ar)                 tmo_cnt <= '0;
        else if (!in_wait || Done) tmo_cnt <= '0;
        else                    tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    assign tmo_hit = TMO_EN && in_wait && !Done && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            state             <= IDLE;
            is_read           <= 1'b0;
            A                 <= '0;
            DIn               <= '0;
            RD                <= 1'b0;
            WR                <= 1'b0;
            Done_LED          <= 1'b0;
            Internal_Pass_LED <= 1'b0;
            Internal_Fail_LED <= 1'b0;
            disp              <= '0;
        end else begin
            RD <= 1'b0;
            WR <= 1'b0;
            case (state)
                IDLE: begin
                    if (IT_Switch) begin
                        if (ev_a) begin
                            Internal_Pass_LED <= 1'b0;
                            Internal_Fail_LED <= 1'b0;
                            Done_LED          <= 1'b0;
                            A                 <= '0;
                            state             <= T_WR;
                        end
                    end else begin
                        if (ev_a) A <= UniversalIn[ADDR_W-1:0];
                        // Write takes priority over a simultaneous read.
                        if (ev_w) begin
                            DIn      <= UniversalIn;
                            WR       <= 1'b1;
                            is_read  <= 1'b0;
                            Done_LED <= 1'b0;
                            state    <= M_WAIT;
                        end else if (ev_r) begin
                            RD       <= 1'b1;
                            is_read  <= 1'b1;
                            Done_LED <= 1'b0;
                            state    <= M_WAIT;
                        end
                    end
                end
                M_WAIT: begin
                    if (Done) begin
                        if (is_read) disp <= DOut;
                        Done_LED <= 1'b1;
                        state    <= IDLE;
                    end else if (tmo_hit) begin
                        disp     <= DATA_W'(16'hDEAD);
                        Done_LED <= 1'b1;
                        state    <= IDLE;
                    end
                end
                T_WR: begin
                    DIn   <= pattern(A);
                    WR    <= 1'b1;
                    state <= T_WWAIT;
                end
                T_WWAIT: begin
                    if (Done) begin
                        A     <= A + ADDR_W'(1);
                        state <= (&A) ? T_RD : T_WR;
                    end else if (tmo_hit) begin
                        Internal_Fail_LED <= 1'b1;
                        disp              <= DATA_W'(16'hDEAD);
                        state             <= FIN;
                    end
                end
                T_RD: begin
                    RD    <= 1'b1;
                    state <= T_RWAIT;
                end
                T_RWAIT: begin
                    if (Done) begin
                        if (DOut != pattern(A)) begin
                            Internal_Fail_LED <= 1'b1;
                            disp              <= DATA_W'(A);
                            state             <= FIN;
                        end else if (&A) begin
                            Internal_Pass_LED <= 1'b1;
                            disp              <= DATA_W'(16'h0400);
                            A                 <= '0;
                            state             <= FIN;
                        end else begin
                            A     <= A + ADDR_W'(1);
                            state <= T_RD;
                        end
                    end else if (tmo_hit) begin
                        Internal_Fail_LED <= 1'b1;
                        disp              <= DATA_W'(16'hDEAD);
                        state             <= FIN;
                    end
                end
                FIN: begin
                    Done_LED <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign SevenSeg_Three = disp[15:12];
    assign SevenSeg_Two   = disp[11:8];
    assign SevenSeg_One   = disp[7:4];
    assign SevenSeg_Zero  = disp[3:0];

endmodule

// File: tb/tb_mem_rw_test.sv
// Self-checking bench for mem_rw_test with a small behavioural RAM controller model.
module tb_mem_rw_test;

    logic        clk = 1'b0;
    logic        ar = 1'b1;
    logic [15:0] ui = '0;
    logic        a_btn = 1'b0, rd_btn = 1'b0, wr_btn = 1'b0, it_sw = 1'b0;
    logic [15:0] dout_bus;
    logic        done_bus;
    logic [9:0]  a;
    logic [15:0] din;
    logic        rd, wr, done_led, pass_led, fail_led;
    logic [3:0]  ss3, ss2, ss1, ss0;
    logic [15:0] disp;

    always #5 clk = ~clk;

    mem_rw_test dut (
        .clk(clk), .ar(ar), .UniversalIn(ui), .A_Button(a_btn), .Rd_Button(rd_btn),
        .Wr_Button(wr_btn), .IT_Switch(it_sw), .DOut(dout_bus), .Done(done_bus),
        .A(a), .DIn(din), .RD(rd), .WR(wr), .Done_LED(done_led),
        .Internal_Pass_LED(pass_led), .Internal_Fail_LED(fail_led),
        .SevenSeg_Three(ss3), .SevenSeg_Two(ss2), .SevenSeg_One(ss1), .SevenSeg_Zero(ss0)
    );

    assign disp = {ss3, ss2, ss1, ss0};

    // Controller model: accepts a strobe, answers with a one-cycle Done three cycles later.
    logic [15:0] mem [1024];
    logic        busy = 1'b0, done_m = 1'b0, op_rd = 1'b0, rd_q = 1'b0, wr_q = 1'b0;
    logic [1:0]  lat = '0;
    logic [9:0]  op_addr = '0;
    logic [15:0] dout_m = '0;
    bit          corrupt = 1'b0, mute = 1'b0, extra_done = 1'b0;
    int          wr_cnt = 0, rd_cnt = 0, overlap_cnt = 0, long_pulse = 0, max_rd_addr = -1;

    assign done_bus = done_m | extra_done;
    assign dout_bus = extra_done ? 16'h5A5A : dout_m;

    always @(posedge clk or posedge ar) begin
        if (ar) begin
            busy <= 1'b0; done_m <= 1'b0; dout_m <= '0; rd_q <= 1'b0; wr_q <= 1'b0;
            lat <= '0; op_rd <= 1'b0; op_addr <= '0; max_rd_addr <= -1;
        end else begin
            done_m <= 1'b0;
            rd_q   <= rd;
            wr_q   <= wr;
            if (busy) begin
                if (lat == 2'd0) begin
                    busy <= 1'b0;
                    if (!mute) begin
                        done_m <= 1'b1;
                        dout_m <= op_rd ? mem[op_addr] : 16'h0000;
                    end
                end else begin
                    lat <= lat - 2'd1;
                end
            end
            if (rd || wr) begin
                if (busy || (rd && wr)) overlap_cnt <= overlap_cnt + 1;
                busy    <= 1'b1;
                lat     <= 2'd2;
                op_addr <= a;
                op_rd   <= rd;
                if (wr) begin
                    mem[a] <= (corrupt && a == 10'h155) ? (din ^ 16'h0100) : din;
                    wr_cnt <= wr_cnt + 1;
                end
                if (rd) begin
                    rd_cnt <= rd_cnt + 1;
                    if (int'(a) > max_rd_addr) max_rd_addr <= int'(a);
                end
            end
            if ((rd && rd_q) || (wr && wr_q)) long_pulse <= long_pulse + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit pa, input bit pr, input bit pw);
        a_btn = pa; rd_btn = pr; wr_btn = pw;
        cyc(4);
        a_btn = 1'b0; rd_btn = 1'b0; wr_btn = 1'b0;
        cyc(12);
    endtask

    task automatic wait_done_led(input string name, input int limit, output int k);
        k = 0;
        while (!done_led && k < limit) begin
            cyc(1);
            k++;
        end
        chk(name, 32'(k < limit), 32'd1);
    endtask

    typedef struct {
        bit          pa, pr, pw;
        logic [15:0] ui;
        logic [9:0]  ea;
        logic [15:0] ed;
        bit          eled;
        int          ewr, erd;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    initial begin
        int w0, r0, k;

        // Manual-mode vectors: {A, Rd, Wr, UniversalIn} -> {A, display, Done_LED, writes, reads}.
        vt[0]  = '{1'b1, 1'b0, 1'b0, 16'h0012, 10'h012, 16'h0000, 1'b0, 0, 0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 16'hBEEF, 10'h012, 16'h0000, 1'b1, 1, 0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 10'h012, 16'hBEEF, 1'b1, 0, 1};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 16'h0345, 10'h345, 16'hBEEF, 1'b1, 0, 0};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 10'h345, 16'hBEEF, 1'b1, 1, 0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 10'h345, 16'h1234, 1'b1, 0, 1};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 16'h0012, 10'h012, 16'h1234, 1'b1, 0, 0};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 10'h012, 16'hBEEF, 1'b1, 0, 1};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 10'h3FF, 16'hBEEF, 1'b1, 0, 0};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 16'hA5A5, 10'h3FF, 16'hBEEF, 1'b1, 1, 0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 10'h3FF, 16'hA5A5, 1'b1, 0, 1};

        cyc(3);
        chk("rst_A", 32'(a), 32'h0);
        chk("rst_strobes", 32'({rd, wr}), 32'h0);
        chk("rst_leds", 32'({done_led, pass_led, fail_led}), 32'h0);
        chk("rst_disp", 32'(disp), 32'h0);
        chk("rst_din", 32'(din), 32'h0);
        ar = 1'b0;
        cyc(3);

        for (int i = 0; i < NV; i++) begin
            w0 = wr_cnt; r0 = rd_cnt;
            ui = vt[i].ui;
            press(vt[i].pa, vt[i].pr, vt[i].pw);
            chk($sformatf("v%0d_A", i), 32'(a), 32'(vt[i].ea));
            chk($sformatf("v%0d_disp", i), 32'(disp), 32'(vt[i].ed));
            chk($sformatf("v%0d_done_led", i), 32'(done_led), 32'(vt[i].eled));
            chk($sformatf("v%0d_writes", i), 32'(wr_cnt - w0), 32'(vt[i].ewr));
            chk($sformatf("v%0d_reads", i), 32'(rd_cnt - r0), 32'(vt[i].erd));
        end
        chk("manual_overlap", 32'(overlap_cnt), 32'h0);
        chk("manual_long_pulse", 32'(long_pulse), 32'h0);

        // Done_LED drops in the cycle the next request issues.
        rd_btn = 1'b1;
        k = 0;
        while (!rd && k < 10) begin cyc(1); k++; end
        chk("clr_rd_seen", 32'(rd), 32'h1);
        chk("clr_done_led", 32'(done_led), 32'h0);
        rd_btn = 1'b0;
        cyc(12);
        chk("clr_done_led_back", 32'(done_led), 32'h1);

        // A Done pulse while idle must not touch the display.
        extra_done = 1'b1;
        cyc(1);
        extra_done = 1'b0;
        cyc(3);
        chk("stray_done_disp", 32'(disp), 32'hA5A5);

        // Healthy self-test, with Rd/Wr presses that must be dropped mid-sweep.
        it_sw = 1'b1;
        w0 = wr_cnt; r0 = rd_cnt;
        a_btn = 1'b1;
        cyc(4);
        a_btn = 1'b0;
        cyc(20);
        rd_btn = 1'b1; wr_btn = 1'b1;
        cyc(4);
        rd_btn = 1'b0; wr_btn = 1'b0;
        wait_done_led("it_ok_finish", 20000, k);
        chk("it_ok_pass", 32'(pass_led), 32'h1);
        chk("it_ok_fail", 32'(fail_led), 32'h0);
        chk("it_ok_disp", 32'(disp), 32'h0400);
        chk("it_ok_writes", 32'(wr_cnt - w0), 32'd1024);
        chk("it_ok_reads", 32'(rd_cnt - r0), 32'd1024);
        chk("it_ok_A_wrap", 32'(a), 32'h0);
        chk("it_ok_overlap", 32'(overlap_cnt), 32'h0);
        chk("it_ok_long_pulse", 32'(long_pulse), 32'h0);
        chk("it_pat_000", 32'(mem[0]), 32'hFC00);
        chk("it_pat_2AA", 32'(mem[682]), 32'h56AA);
        chk("it_pat_3FF", 32'(mem[1023]), 32'h03FF);
        cyc(5);

        // Reset in the middle of a sweep aborts immediately.
        a_btn = 1'b1;
        cyc(4);
        a_btn = 1'b0;
        cyc(40);
        ar = 1'b1;
        #1;
        chk("abort_A", 32'(a), 32'h0);
        chk("abort_strobes", 32'({rd, wr}), 32'h0);
        chk("abort_leds", 32'({done_led, pass_led, fail_led}), 32'h0);
        chk("abort_disp", 32'(disp), 32'h0);
        cyc(2);
        ar = 1'b0;
        cyc(3);

        // Corrupted location 0x155 must stop the read pass there.
        corrupt = 1'b1;
        w0 = wr_cnt; r0 = rd_cnt;
        a_btn = 1'b1;
        cyc(4);
        a_btn = 1'b0;
        wait_done_led("it_bad_finish", 20000, k);
        chk("it_bad_fail", 32'(fail_led), 32'h1);
        chk("it_bad_pass", 32'(pass_led), 32'h0);
        chk("it_bad_disp", 32'(disp), 32'h0155);
        chk("it_bad_writes", 32'(wr_cnt - w0), 32'd1024);
        chk("it_bad_reads", 32'(rd_cnt - r0), 32'h156);
        chk("it_bad_max_rd", 32'(max_rd_addr), 32'h155);
        cyc(20);
        chk("it_bad_no_more_reads", 32'(rd_cnt - r0), 32'h156);
        corrupt = 1'b0;
        it_sw = 1'b0;

`ifdef MEMRW_TIMEOUT_EN
        // Controller never answers: manual read times out after 255 cycles.
        mute = 1'b1;
        rd_btn = 1'b1;
        k = 0;
        while (!rd && k < 10) begin cyc(1); k++; end
        chk("tmo_rd_seen", 32'(rd), 32'h1);
        rd_btn = 1'b0;
        wait_done_led("tmo_finish", 400, k);
        chk("tmo_latency", 32'(k >= 254 && k <= 256), 32'h1);
        chk("tmo_disp", 32'(disp), 32'hDEAD);
        mute = 1'b0;
        cyc(5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
        $fatal(1);
    end

endmodule
